// File: rtl/axi_apb_xfer_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// axi_apb_xfer_scheduler_pkg
//   Shared types for the AXI-to-APB transfer scheduler: APB/AXI response codes,
//   scheduler FSM states, the arbiter grant direction and the width of the
//   slave-select field carried in the address.
// ----------------------------------------------------------------------------
package axi_apb_xfer_scheduler_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10,
        RESP   = 2'b11
    } sched_state_t;

    typedef enum logic {
        WRITE = 1'b0,
        READ  = 1'b1
    } grant_t;

    // The slave index is always a 3-bit field, so at most 8 slaves exist.
    localparam int unsigned SLV_IDX_W = 3;

    // Response code for an ACCESS phase completed by pready.
    function automatic resp_t access_resp(input logic slverr);
        return slverr ? SLVERR : OKAY;
    endfunction

endpackage

// File: rtl/axi_apb_xfer_scheduler_arb.sv
// ----------------------------------------------------------------------------
// apb_rr_arbiter_2
//   Two-requester round-robin arbiter (write vs read). On a tie, the side that
//   was not granted last wins. Grants are combinational and only issued while
//   enable is high; last_grant updates on the accept strobe.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   wr_req, rd_req    pending write / read request
//   enable            scheduler is idle and may grant
//   accept            a grant is being taken this cycle
//   wr_gnt, rd_gnt    one-hot grant (or none)
// ----------------------------------------------------------------------------
module apb_rr_arbiter_2
    import axi_apb_xfer_scheduler_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic wr_req,
    input  logic rd_req,
    input  logic enable,
    input  logic accept,
    output logic wr_gnt,
    output logic rd_gnt
);

    grant_t last_grant;

    always_comb begin
        wr_gnt = enable && wr_req && (!rd_req || (last_grant == READ));
        rd_gnt = enable && rd_req && (!wr_req || (last_grant == WRITE));
    end

    // Starting at READ lets a write win the first tie after reset.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= READ;
        end else if (accept) begin
            last_grant <= wr_gnt ? WRITE : READ;
        end
    end

endmodule

// File: rtl/axi_apb_xfer_scheduler.sv
// ----------------------------------------------------------------------------
// axi_apb_xfer_scheduler
//   Shares one APB master port between the collected write path and the read
//   path. Round-robin grants one request at a time, decodes the slave select
//   from the address, sequences SETUP/ACCESS, bounds the ACCESS wait with an
//   optional timeout and hands the response back to the B or R channel logic.
//
// Ports:
//   clk, reset_n                      bridge clock (= pclk), async active-low reset
//   wr_req_valid/ready/addr/data      write request handshake
//   wr_rsp_valid/ready/resp           write response handshake
//   rd_req_valid/ready/addr           read request handshake
//   rd_rsp_valid/ready/data/resp      read response handshake
//   paddr, pwrite, pwdata, psel,
//   penable                           APB master outputs
//   prdata, pready, pslverr           APB slave returns
// ----------------------------------------------------------------------------
module axi_apb_xfer_scheduler
    import axi_apb_xfer_scheduler_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NUM_SLAVES     = 6,
    parameter int unsigned SLV_SEL_LSB    = 12,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_req_valid,
    output logic                  wr_req_ready,
    input  logic [ADDR_WIDTH-1:0] wr_req_addr,
    input  logic [DATA_WIDTH-1:0] wr_req_data,
    output logic                  wr_rsp_valid,
    input  logic                  wr_rsp_ready,
    output logic [1:0]            wr_rsp_resp,
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    input  logic [ADDR_WIDTH-1:0] rd_req_addr,
    output logic                  rd_rsp_valid,
    input  logic                  rd_rsp_ready,
    output logic [DATA_WIDTH-1:0] rd_rsp_data,
    output logic [1:0]            rd_rsp_resp,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic [NUM_SLAVES-1:0] psel,
    output logic                  penable,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [SLV_IDX_W:0] NUM_SLV = (SLV_IDX_W + 1)'(NUM_SLAVES);

    sched_state_t          state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  write_q;
    logic [SLV_IDX_W-1:0]  idx_q;
    resp_t                 resp_q;
    logic [CNT_W-1:0]      k_q;

    logic                  wr_gnt;
    logic                  rd_gnt;
    logic                  accept;
    logic                  arb_enable;
    logic [SLV_IDX_W-1:0]  req_idx;
    logic                  decode_ok;
    logic                  rsp_hs;
    logic                  apb_active;

    // Gating with reset_n keeps req_ready low while reset is held, even though
    // the FSM already sits in IDLE.
    assign arb_enable = (state_q == IDLE) && reset_n;
    assign accept     = wr_gnt || rd_gnt;

    apb_rr_arbiter_2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_req  (wr_req_valid),
        .rd_req  (rd_req_valid),
        .enable  (arb_enable),
        .accept  (accept),
        .wr_gnt  (wr_gnt),
        .rd_gnt  (rd_gnt)
    );

    assign wr_req_ready = wr_gnt;
    assign rd_req_ready = rd_gnt;

    assign req_idx   = wr_gnt ? wr_req_addr[SLV_SEL_LSB +: SLV_IDX_W]
                              : rd_req_addr[SLV_SEL_LSB +: SLV_IDX_W];
    assign decode_ok = {1'b0, req_idx} < NUM_SLV;

    assign rsp_hs = (state_q == RESP) && (write_q ? wr_rsp_ready : rd_rsp_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            write_q <= 1'b0;
            idx_q   <= '0;
            resp_q  <= OKAY;
            k_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= wr_gnt ? wr_req_addr : rd_req_addr;
                        wdata_q <= wr_gnt ? wr_req_data : '0;
                        write_q <= wr_gnt;
                        idx_q   <= req_idx;
                        // Cleared here so error and timeout exits return 0.
                        rdata_q <= '0;
                        resp_q  <= decode_ok ? OKAY : DECERR;
                        state_q <= decode_ok ? SETUP : RESP;
                    end
                end
                SETUP: begin
                    state_q <= ACCESS;
                    k_q     <= CNT_W'(1);
                end
                ACCESS: begin
                    if (pready) begin
                        resp_q  <= access_resp(pslverr);
                        if (!write_q && !pslverr) begin
                            rdata_q <= prdata;
                        end
                        state_q <= RESP;
                    end else if ((TIMEOUT_CYCLES != 0) && (k_q == TMO_LIMIT)) begin
                        resp_q  <= SLVERR;
                        state_q <= RESP;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        k_q <= k_q + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_hs) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // APB strobes are decoded from state so they drop the moment reset asserts.
    assign apb_active = (state_q == SETUP) || (state_q == ACCESS);

    // NOTE: every always_comb output gets a default before any conditional
    // assignment so no path can leave it unassigned and infer a latch.
    always_comb begin
        psel = '0;
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            psel[i] = apb_active && (idx_q == SLV_IDX_W'(i));
        end
    end

    assign penable = (state_q == ACCESS);
    assign pwrite  = apb_active && write_q;
    assign paddr   = addr_q;
    assign pwdata  = wdata_q;

    assign wr_rsp_valid = (state_q == RESP) && write_q;
    assign rd_rsp_valid = (state_q == RESP) && !write_q;
    assign wr_rsp_resp  = resp_q;
    assign rd_rsp_resp  = resp_q;
    assign rd_rsp_data  = rdata_q;

endmodule
